// File: rtl/bsg_bladerunner_rom_reader.sv
// Fetches every word of the bladerunner configuration ROM through a manycore
// endpoint, throttled by a local credit counter, and exposes the words by index.
module bsg_bladerunner_rom_reader #(
  parameter int rom_els_p         = 32,
  parameter int rom_width_p       = 32,
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 16,
  parameter int lg_rom_els_lp     = (rom_els_p > 1) ? $clog2(rom_els_p) : 1,
  parameter int lg_credits_lp     = (max_out_credits_p + 1 > 1) ? $clog2(max_out_credits_p + 1) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     out_v_o,
  output logic [addr_width_p-1:0]  out_addr_o,
  input  logic                     out_ready_i,
  input  logic                     returned_v_i,
  input  logic [data_width_p-1:0]  returned_data_i,
  output logic                     returned_yumi_o,
  input  logic [lg_rom_els_lp-1:0] rd_idx_i,
  output logic [rom_width_p-1:0]   rd_data_o
);

  // Counters must reach rom_els_p itself, one more value than an index needs.
  localparam int cnt_width_lp = $clog2(rom_els_p + 1);

  localparam logic [cnt_width_lp-1:0]  last_idx_lp    = cnt_width_lp'(rom_els_p - 1);
  localparam logic [cnt_width_lp-1:0]  rom_els_cnt_lp = cnt_width_lp'(rom_els_p);
  localparam logic [lg_credits_lp-1:0] max_credits_lp = lg_credits_lp'(max_out_credits_p);
  localparam logic [lg_rom_els_lp:0]   rom_els_ext_lp = (lg_rom_els_lp + 1)'(rom_els_p);

  typedef enum logic [1:0] {
    e_idle,
    e_issue,
    e_drain,
    e_done
  } state_e;

  state_e                   state_r, state_n;
  logic [cnt_width_lp-1:0]  issue_cnt_r, ret_cnt_r, ret_cnt_n;
  logic [lg_credits_lp-1:0] credits_r;
  logic                     err_r;
  logic                     fire, resp_ok, start_clr;
  logic [rom_width_p-1:0]   mem_r [rom_els_p];

  assign fire            = out_v_o & out_ready_i;
  assign resp_ok         = returned_v_i & (ret_cnt_r < issue_cnt_r);
  assign start_clr       = start_i & ((state_r == e_idle) | (state_r == e_done));
  assign ret_cnt_n       = resp_ok ? ret_cnt_r + cnt_width_lp'(1) : ret_cnt_r;
  assign returned_yumi_o = returned_v_i;
  assign err_o           = err_r;
  assign out_addr_o      = addr_width_p'(issue_cnt_r);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      issue_cnt_r <= '0;
      ret_cnt_r   <= '0;
      credits_r   <= max_credits_lp;
      err_r       <= 1'b0;
    end else begin
      if (returned_v_i & ~resp_ok) begin
        err_r <= 1'b1;
      end
      if (start_clr) begin
        issue_cnt_r <= '0;
        ret_cnt_r   <= '0;
      end else begin
        if (fire) begin
          issue_cnt_r <= issue_cnt_r + cnt_width_lp'(1);
        end
        ret_cnt_r <= ret_cnt_n;
      end
      // A simultaneous request and response cancel out.
      if (fire & ~resp_ok) begin
        credits_r <= credits_r - lg_credits_lp'(1);
      end else if (resp_ok & ~fire & (credits_r != max_credits_lp)) begin
        credits_r <= credits_r + lg_credits_lp'(1);
      end
    end
  end

  // NOTE: every variable in a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle:  if (start_i) state_n = e_issue;
      e_issue: if (fire && (issue_cnt_r == last_idx_lp)) state_n = e_drain;
      e_drain: if (ret_cnt_n == rom_els_cnt_lp) state_n = e_done;
      e_done:  if (start_i) state_n = e_issue;
      default: state_n = e_idle;
    endcase
  end

  always_comb begin
    out_v_o = (state_r == e_issue) && (credits_r != '0);
    busy_o  = (state_r == e_issue) || (state_r == e_drain);
    done_o  = (state_r == e_done);
  end

  // NOTE: the word storage has no reset; its contents only matter once done_o
  // is high, and leaving it unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk_i) begin
    if (resp_ok) begin
      mem_r[ret_cnt_r[lg_rom_els_lp-1:0]] <= returned_data_i[rom_width_p-1:0];
    end
  end

  always_comb begin
    rd_data_o = '0;
    if ({1'b0, rd_idx_i} < rom_els_ext_lp) begin
      rd_data_o = mem_r[rd_idx_i];
    end
  end

endmodule

// File: tb/tb_bsg_bladerunner_rom_reader.sv
// Randomized scoreboard bench for bsg_bladerunner_rom_reader: a monitor checks
// handshakes and status against a counting model of the fetch sequence.
module tb_bsg_bladerunner_rom_reader;

  localparam int N   = 6;
  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset_i, start_i, out_ready_i, returned_v_i;
  logic [31:0] returned_data_i;
  logic [2:0]  rd_idx_i;
  logic        busy_o, done_o, err_o, out_v_o, returned_yumi_o;
  logic [27:0] out_addr_o;
  logic [31:0] rd_data_o;

  bsg_bladerunner_rom_reader #(
    .rom_els_p(N), .rom_width_p(32), .addr_width_p(28),
    .data_width_p(32), .max_out_credits_p(MAX)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .out_v_o(out_v_o), .out_addr_o(out_addr_o), .out_ready_i(out_ready_i),
    .returned_v_i(returned_v_i), .returned_data_i(returned_data_i),
    .returned_yumi_o(returned_yumi_o),
    .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the fetch sequence in terms of handshakes seen at the ports.
  bit          seq_active = 0;
  bit          err_model  = 0;
  int          fires = 0, returned = 0, outstanding = 0;
  int          fire_first = 0, fire_last = 0;
  int          exp_addr_q[$];
  logic [31:0] rom_exp [N];

  typedef struct { int addr; int due; } pend_t;
  pend_t pend_q[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit rand_ready = 0, ready_force = 1, a0_mode = 1, spurious_req = 0;
  int min_dly = 1, max_dly = 1;

  // Monitor: compare status, pop expected addresses, record accepted data.
  always @(negedge clk) begin
    if (reset_i) begin
      seq_active  = 0;
      fires       = 0;
      returned    = 0;
      outstanding = 0;
      err_model   = 0;
      exp_addr_q.delete();
    end else begin
      check("out_v", 32'(out_v_o), 32'(seq_active && fires < N && outstanding < MAX));
      check("busy",  32'(busy_o),  32'(seq_active && returned < N));
      check("done",  32'(done_o),  32'(seq_active && returned == N));
      check("err",   32'(err_o),   32'(err_model));
      check("yumi",  32'(returned_yumi_o), 32'(returned_v_i));
      if (out_v_o && out_ready_i) begin
        if (exp_addr_q.size() == 0) begin
          check("fire_unexpected", 32'(out_addr_o), 32'hFFFF_FFFF);
        end else begin
          check("fire_addr", 32'(out_addr_o), 32'(exp_addr_q.pop_front()));
        end
        if (fires == 0) fire_first = cyc;
        fire_last = cyc;
        fires++;
        outstanding++;
        pend_q.push_back('{addr: int'(out_addr_o), due: cyc + int'($urandom_range(max_dly, min_dly))});
      end else if (out_v_o && exp_addr_q.size() > 0) begin
        check("stall_addr", 32'(out_addr_o), 32'(exp_addr_q[0]));
      end
      if (returned_v_i) begin
        if (outstanding > 0) begin
          rom_exp[returned] = returned_data_i;
          returned++;
          outstanding--;
        end else begin
          err_model = 1;
        end
      end
    end
  end

  // Endpoint responder: returns each request after its scheduled delay.
  initial begin
    pend_t p;
    returned_v_i    = 1'b0;
    returned_data_i = '0;
    out_ready_i     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready_i     = rand_ready ? ($urandom_range(3, 0) != 0) : ready_force;
      returned_v_i    = 1'b0;
      returned_data_i = $urandom;
      if (spurious_req) begin
        returned_v_i    = 1'b1;
        returned_data_i = 32'h55;
        spurious_req    = 0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p               = pend_q.pop_front();
        returned_v_i    = 1'b1;
        returned_data_i = a0_mode ? 32'hA0 + 32'(p.addr) : $urandom;
      end
    end
  end

  task automatic start_seq();
    start_i = 1'b1;
    for (int i = 0; i < N; i++) exp_addr_q.push_back(i);
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    fires      = 0;
    returned   = 0;
    seq_active = 1;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 2000 && !done_o; k++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(done_o), 32'd1);
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      rd_idx_i = 3'(i);
      #1;
      check("rd_data", rd_data_o, (i < N) ? rom_exp[i] : 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fires(input int n);
    for (int k = 0; k < 500 && fires < n; k++) begin
      @(posedge clk);
      #1;
    end
    check("wait_fires", 32'(fires >= n), 32'd1);
  endtask

  initial begin
    int f0;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    rd_idx_i = '0;
    #12;
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_done",  32'(done_o),  32'd0);
    check("rst_err",   32'(err_o),   32'd0);
    check("rst_out_v", 32'(out_v_o), 32'd0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Spurious response while idle.
    spurious_req = 1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_err",  32'(err_o),  32'd1);
    check("idle_done", 32'(done_o), 32'd0);

    // Back-to-back fetch with a one-cycle responder.
    start_seq();
    wait_done("run1_done");
    check("run1_back_to_back", 32'(fire_last - fire_first), 32'(N - 1));
    rd_idx_i = 3'd2;
    #1;
    check("run1_rd2", rd_data_o, 32'hA2);
    read_all();

    // Random ready and random response latency.
    a0_mode    = 0;
    rand_ready = 1;
    max_dly    = 5;
    start_seq();
    wait_done("run2_done");
    read_all();

    // Restart from DONE, stall mid-issue, then start during drain.
    rand_ready = 0;
    min_dly    = 2;
    max_dly    = 4;
    start_seq();
    check("restart_done_clr", 32'(done_o), 32'd0);
    wait_fires(2);
    ready_force = 0;
    @(posedge clk);
    #2;
    f0 = fires;
    repeat (3) @(posedge clk);
    #2;
    check("stall_no_fire", 32'(fires), 32'(f0));
    ready_force = 1;
    #1;
    for (int k = 0; k < 500 && !(fires == N && returned < N); k++) begin
      @(posedge clk);
      #1;
    end
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done("run3_done");
    read_all();

    // Asynchronous reset in the middle of issuing.
    min_dly = 3;
    max_dly = 5;
    start_seq();
    wait_fires(2);
    #2;
    reset_i = 1'b1;
    #1;
    check("async_out_v", 32'(out_v_o), 32'd0);
    check("async_busy",  32'(busy_o),  32'd0);
    check("async_done",  32'(done_o),  32'd0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    #1;
    check("post_rst_busy",  32'(busy_o),  32'd0);
    check("post_rst_out_v", 32'(out_v_o), 32'd0);
    repeat (10) @(posedge clk);
    #1;

    // Full random fetch after reset recovery.
    rand_ready = 1;
    min_dly    = 1;
    start_seq();
    wait_done("run4_done");
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bsg_bladerunner_rom_reader.md
Name: bsg_bladerunner_rom_reader

Overview:
Host-side requester that sits directly upstream of the bladerunner configuration ROM tile. On a start pulse it issues one load request per ROM word, addresses 0..rom_els_p-1, through the manycore endpoint's out-packet/returned-data interface. It throttles requests with its own credit counter, captures the in-order responses into a local register file, and raises done once every word has returned. Host logic then reads the captured configuration words combinationally by index.

Parameters:
rom_els_p, 32, number of ROM words to fetch (>=1)
rom_width_p, 32, width of each captured word (<= data_width_p)
addr_width_p, 28, manycore EPA address width
data_width_p, 32, manycore data width
max_out_credits_p, 16, maximum outstanding loads (>=1)
lg_rom_els_lp, `BSG_SAFE_CLOG2(rom_els_p), local index width
lg_credits_lp, `BSG_SAFE_CLOG2(max_out_credits_p+1), credit counter width

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-high
start_i  in  1  pulse that begins a fetch sequence
busy_o  out  1  high in ISSUE or DRAIN
done_o  out  1  all rom_els_p words captured
err_o  out  1  sticky; a response arrived while none was outstanding
out_v_o  out  1  load request valid
out_addr_o  out  addr_width_p  request EPA, equal to the word index zero-extended
out_ready_i  in  1  endpoint accepts the request this cycle
returned_v_i  in  1  load response valid
returned_data_i  in  data_width_p  response data
returned_yumi_o  out  1  response consumed
rd_idx_i  in  lg_rom_els_lp  host read index
rd_data_o  out  rom_width_p  captured word at rd_idx_i (combinational)

Behaviour:
- Async reset sets: state=IDLE, issue_cnt=0, ret_cnt=0, credits=max_out_credits_p, done_o=0, err_o=0, busy_o=0, out_v_o=0. The register file is not reset; its contents are undefined until done_o.
- States:
  - IDLE: start_i moves to ISSUE; issue_cnt and ret_cnt clear to 0.
  - ISSUE: runs until the last request is handshaken, then moves to DRAIN.
  - DRAIN: runs until ret_cnt reaches rom_els_p, then moves to DONE.
  - DONE: done_o=1. start_i clears done_o, clears both counters and moves to ISSUE. The register file keeps old data until each word is overwritten.
- start_i is ignored in ISSUE and DRAIN.
- Request: out_v_o = (state==ISSUE) & (credits!=0). out_addr_o = addr_width_p'(issue_cnt). A request fires on out_v_o & out_ready_i; issue_cnt then increments.
  - When the fire carries index rom_els_p-1, the next state is DRAIN, even if responses are still pending.
  - out_v_o does not depend combinationally on out_ready_i.
- Response: returned_yumi_o = returned_v_i, so responses are always accepted in the same cycle.
  - If ret_cnt < issue_cnt, data[ret_cnt] <= returned_data_i[rom_width_p-1:0] and ret_cnt increments. Responses are in-order because all requests target a single endpoint.
  - If ret_cnt >= issue_cnt, the response is dropped, err_o is set (sticky until reset), and the counters are unchanged.
- Credits:
  - A request fire decrements the counter; a valid accepted response increments it.
  - Both in the same cycle leave it unchanged.
  - The counter never exceeds max_out_credits_p. A spurious response does not increment it.
- If a request fire and the last response land in the same cycle, both take effect.
- The ISSUE→DRAIN and DRAIN→DONE checks use the post-update counters. For rom_els_p outstanding at once, DRAIN is entered first, then DONE.
- Latency: with out_ready_i=1 and a one-cycle response, one request issues per cycle. done_o rises one cycle after the cycle in which the last response is accepted.
- rd_data_o = data[rd_idx_i]; an index >= rom_els_p returns '0.
- Reset asserted mid-sequence aborts immediately: out_v_o drops asynchronously, and in-flight responses arriving after release set err_o.

Test Plan:
- rom_els_p=4, out_ready_i=1, responder returns 0xA0+addr one cycle after each request → out_addr_o sequence 0,1,2,3 on consecutive cycles; done_o=1; rd_idx_i=2 gives rd_data_o=0xA2.
- max_out_credits_p=2, rom_els_p=8, responder delays 5 cycles → never more than 2 outstanding; out_v_o=0 while credits=0; all 8 words captured correctly.
- Hold out_ready_i=0 for 3 cycles mid-ISSUE → out_v_o stays 1, out_addr_o stays stable, issue_cnt unchanged; sequence resumes with no gap or duplicate.
- returned_v_i pulse while in IDLE with data 0x55 → err_o=1, credits stay at max, no register written, done_o stays 0.
- Complete a run, then assert start_i in DONE → done_o clears next cycle and the addresses restart at 0. start_i pulsed during DRAIN is ignored.
- Assert reset_i asynchronously (mid-cycle) during ISSUE after 2 issues → out_v_o, busy_o and done_o are 0 before the next edge; after reset release, the state is IDLE with credits=max.
